// File: rtl/fetch_sequencer.sv
// Fetch front end: issues 8-byte I-cache requests, tags and buffers responses for the aligner.
// Define FETCH_SEQ_PERF_CNT_EN to add saturating issue/drop performance counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_req_valid,
  output logic [31:0] o_req_pc,
  input  logic        i_req_ready,
  input  logic        i_resp_valid,
  input  logic [63:0] i_resp_data,
  input  logic        i_resp_fault,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [63:0] o_data,
  output logic        o_fault,
  output logic        o_flush
`ifdef FETCH_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] o_perf_issue_cnt,
  output logic [31:0] o_perf_drop_cnt
`endif
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MAX_OUTSTANDING - 1);
  localparam logic [3:0] MaxCredit = 4'(MAX_OUTSTANDING);

  localparam logic [1:0] StBoot = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StHalt = 2'd2;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic [2:0]  drop_cnt_q, drop_cnt_d;

  // Tag FIFO holds the PC of each live (non-stale) in-flight request.
  logic [31:0]     tag_mem_q [MAX_OUTSTANDING];
  logic [31:0]     tag_mem_d [MAX_OUTSTANDING];
  logic [PtrW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;

  // Response FIFO entry: {pc, data, fault}.
  logic [96:0]     rsp_mem_q [MAX_OUTSTANDING];
  logic [96:0]     rsp_mem_d [MAX_OUTSTANDING];
  logic [PtrW-1:0] rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [2:0]      rsp_cnt_q, rsp_cnt_d;

  logic [3:0]  credit;
  logic        issue, resp_keep, resp_drop, tag_pop, pop;
  logic [96:0] head;

  always_comb begin
    credit      = {1'b0, outstanding_q} + {1'b0, rsp_cnt_q};
    o_req_valid = (state_q == StRun) & ~i_redirect & (credit < MaxCredit);
    o_req_pc    = fetch_pc_q;
    o_flush     = i_redirect;
    issue       = o_req_valid & i_req_ready;
    resp_keep   = i_resp_valid & ~i_redirect & (drop_cnt_q == 3'd0) & (state_q != StHalt);
    resp_drop   = i_resp_valid & ~resp_keep;
    tag_pop     = i_resp_valid & (drop_cnt_q == 3'd0);
    head        = rsp_mem_q[rsp_rd_q];
    o_valid     = (rsp_cnt_q != 3'd0);
    o_pc        = o_valid ? head[96:65] : 32'h0;
    o_data      = o_valid ? head[64:1]  : 64'h0;
    o_fault     = o_valid & head[0];
    pop         = o_valid & ~i_stall;
  end

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q + 3'(issue) - 3'(i_resp_valid);
    drop_cnt_d    = drop_cnt_q;
    tag_mem_d     = tag_mem_q;
    tag_wr_d      = tag_wr_q;
    tag_rd_d      = tag_rd_q;
    rsp_mem_d     = rsp_mem_q;
    rsp_wr_d      = rsp_wr_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_cnt_d     = rsp_cnt_q + 3'(resp_keep) - 3'(pop);

    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   if (resp_keep && i_resp_fault) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StBoot;
    endcase

    if (issue) begin
      fetch_pc_d          = {fetch_pc_q[31:3] + 29'd1, 3'b000};
      tag_mem_d[tag_wr_q] = fetch_pc_q;
      tag_wr_d            = ptr_inc(tag_wr_q);
    end
    if (tag_pop) tag_rd_d = ptr_inc(tag_rd_q);
    if (i_resp_valid && drop_cnt_q != 3'd0) drop_cnt_d = drop_cnt_q - 3'd1;

    if (resp_keep) begin
      rsp_mem_d[rsp_wr_q] = {tag_mem_q[tag_rd_q], i_resp_data, i_resp_fault};
      rsp_wr_d            = ptr_inc(rsp_wr_q);
    end
    if (pop) rsp_rd_d = ptr_inc(rsp_rd_q);

    // Redirect: everything in flight becomes stale, buffered blocks are discarded.
    if (i_redirect) begin
      state_d    = StRun;
      fetch_pc_d = i_redirect_pc & 32'hFFFF_FFFC;
      drop_cnt_d = outstanding_q - 3'(i_resp_valid);
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      rsp_wr_d   = '0;
      rsp_rd_d   = '0;
      rsp_cnt_d  = 3'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= StBoot;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 3'd0;
      drop_cnt_q    <= 3'd0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      rsp_wr_q      <= '0;
      rsp_rd_q      <= '0;
      rsp_cnt_q     <= 3'd0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_cnt_q     <= rsp_cnt_d;
    end
  end

  // Storage needs no reset: reads are gated by the pointers and counts.
  always_ff @(posedge i_clk) begin
    tag_mem_q <= tag_mem_d;
    rsp_mem_q <= rsp_mem_d;
  end

`ifdef FETCH_SEQ_PERF_CNT_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_drop_q, perf_drop_d;

  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_drop_d  = perf_drop_q;
    if (issue && perf_issue_q != 32'hFFFF_FFFF) perf_issue_d = perf_issue_q + 32'd1;
    if (resp_drop && perf_drop_q != 32'hFFFF_FFFF) perf_drop_d = perf_drop_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_issue_q <= 32'd0;
      perf_drop_q  <= 32'd0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_drop_q  <= perf_drop_d;
    end
  end

  assign o_perf_issue_cnt = perf_issue_q;
  assign o_perf_drop_cnt  = perf_drop_q;
`else
  logic unused_resp_drop;
  assign unused_resp_drop = resp_drop;
`endif

`ifndef SYNTHESIS
  resp_without_request_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_resp_valid |-> (outstanding_q != 3'd0));
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer (default build, MAX_OUTSTANDING=2).
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        req_valid;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_fault;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [63:0] o_data;
  logic        o_fault;
  logic        o_flush;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer #(
    .RESET_PC       (32'h8000_0000),
    .MAX_OUTSTANDING(2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_stall      (stall),
    .o_req_valid  (req_valid),
    .o_req_pc     (req_pc),
    .i_req_ready  (req_ready),
    .i_resp_valid (resp_valid),
    .i_resp_data  (resp_data),
    .i_resp_fault (resp_fault),
    .o_valid      (o_valid),
    .o_pc         (o_pc),
    .o_data       (o_data),
    .o_fault      (o_fault),
    .o_flush      (o_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns just after the next rising edge; inputs for the new cycle are driven then.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect = 0; redirect_pc = '0; stall = 0; req_ready = 0;
    resp_valid = 0; resp_data = '0; resp_fault = 0;
  endtask

  // Leaves the DUT at the start of its first RUN cycle.
  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    cyc(); cyc();
    rst_n = 1;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid got %b want 0", req_valid); end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
    n_tests++; if ({o_pc, o_data, o_fault} !== 97'd0) begin n_fail++; $display("FAIL reset_outputs got %h/%h/%b want 0", o_pc, o_data, o_fault); end
    cyc();
    rst_n = 1;
    req_ready = 1; #1;
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL boot_no_req got %b want 0", req_valid); end
    req_ready = 0;
    cyc(); #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL first_req got %b/%h want 1/80000000", req_valid, req_pc); end
  endtask

  task automatic test_basic();
    apply_reset();
    req_ready = 1; #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_req0 got %b/%h want 1/80000000", req_valid, req_pc); end
    cyc();
    resp_valid = 1; resp_data = 64'hA0A0_0000_0000_0001; #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL basic_req1 got %b/%h want 1/80000008", req_valid, req_pc); end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency got %b want 0", o_valid); end
    cyc();
    resp_data = 64'hA0A0_0000_0000_0002; #1;
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL basic_credit got %b want 0", req_valid); end
    n_tests++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0000 || o_data !== 64'hA0A0_0000_0000_0001) begin n_fail++; $display("FAIL basic_out0 got %b/%h/%h want 1/80000000/a0a0000000000001", o_valid, o_pc, o_data); end
    cyc();
    resp_valid = 0; #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL basic_req2 got %b/%h want 1/80000010", req_valid, req_pc); end
    n_tests++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0008 || o_data !== 64'hA0A0_0000_0000_0002) begin n_fail++; $display("FAIL basic_out1 got %b/%h/%h want 1/80000008/a0a0000000000002", o_valid, o_pc, o_data); end
    cyc();
    req_ready = 0; resp_valid = 1; resp_data = 64'hA0A0_0000_0000_0003; #1;
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL basic_empty got %b want 0", o_valid); end
    cyc();
    resp_valid = 0; #1;
    n_tests++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0010 || o_data !== 64'hA0A0_0000_0000_0003) begin n_fail++; $display("FAIL basic_out2 got %b/%h/%h want 1/80000010/a0a0000000000003", o_valid, o_pc, o_data); end
  endtask

  task automatic test_ready_low();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL hold_req[%0d] got %b/%h want 1/80000000", i, req_valid, req_pc); end
      cyc();
    end
    req_ready = 1;
    cyc();
    req_ready = 0; #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL hold_after got %b/%h want 1/80000008", req_valid, req_pc); end
  endtask

  task automatic test_credit_stall();
    apply_reset();
    req_ready = 1; stall = 1;
    cyc();
    resp_valid = 1; resp_data = 64'h1;
    cyc();
    resp_data = 64'h2; #1;
    n_tests++; if (req_valid !== 1'b0 || o_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL credit_c3 got %b/%h want 0/80000000", req_valid, o_pc); end
    cyc();
    resp_valid = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++; if (req_valid !== 1'b0 || o_valid !== 1'b1 || o_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL credit_full[%0d] got %b/%b/%h want 0/1/80000000", i, req_valid, o_valid, o_pc); end
      cyc();
    end
    stall = 0;
    cyc(); #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL credit_resume got %b/%h want 1/80000010", req_valid, req_pc); end
    n_tests++; if (o_pc !== 32'h8000_0008 || o_data !== 64'h2) begin n_fail++; $display("FAIL credit_second got %h/%h want 80000008/2", o_pc, o_data); end
  endtask

  task automatic test_redirect();
    apply_reset();
    req_ready = 1;
    cyc();
    cyc();
    redirect = 1; redirect_pc = 32'h0000_1006; resp_valid = 1; resp_data = 64'hDEAD; #1;
    n_tests++; if (o_flush !== 1'b1 || req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_cycle got %b/%b want 1/0", o_flush, req_valid); end
    cyc();
    redirect = 0; resp_data = 64'hBEEF; #1;
    n_tests++; if (o_flush !== 1'b0 || req_valid !== 1'b1 || req_pc !== 32'h0000_1004) begin n_fail++; $display("FAIL redir_first got %b/%b/%h want 0/1/00001004", o_flush, req_valid, req_pc); end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL redir_drop_a got %b want 0", o_valid); end
    cyc();
    resp_data = 64'h1004; #1;
    n_tests++; if (o_valid !== 1'b0 || req_pc !== 32'h0000_1008) begin n_fail++; $display("FAIL redir_drop_b got %b/%h want 0/00001008", o_valid, req_pc); end
    cyc();
    resp_valid = 0; #1;
    n_tests++; if (o_valid !== 1'b1 || o_pc !== 32'h0000_1004 || o_data !== 64'h1004) begin n_fail++; $display("FAIL redir_out got %b/%h/%h want 1/00001004/1004", o_valid, o_pc, o_data); end
  endtask

  task automatic test_redirect_stall();
    apply_reset();
    req_ready = 1;
    cyc();
    resp_valid = 1; resp_data = 64'h5;
    cyc();
    stall = 1; redirect = 1; redirect_pc = 32'h0000_3000; resp_data = 64'h6; #1;
    n_tests++; if (o_valid !== 1'b1 || o_flush !== 1'b1) begin n_fail++; $display("FAIL rstall_before got %b/%b want 1/1", o_valid, o_flush); end
    cyc();
    redirect = 0; resp_valid = 0; #1;
    n_tests++; if (o_valid !== 1'b0 || req_valid !== 1'b1 || req_pc !== 32'h0000_3000) begin n_fail++; $display("FAIL rstall_after got %b/%b/%h want 0/1/00003000", o_valid, req_valid, req_pc); end
  endtask

  task automatic test_fault();
    apply_reset();
    req_ready = 1;
    cyc();
    cyc();
    resp_valid = 1; resp_data = 64'h10;
    cyc();
    resp_valid = 0;
    cyc(); #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL fault_req_c got %b/%h want 1/80000010", req_valid, req_pc); end
    cyc();
    resp_valid = 1; resp_fault = 1; resp_data = 64'hF00D;
    cyc();
    resp_fault = 0; resp_data = 64'h30; stall = 1; #1;
    n_tests++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0008 || o_fault !== 1'b1) begin n_fail++; $display("FAIL fault_out got %b/%h/%b want 1/80000008/1", o_valid, o_pc, o_fault); end
    n_tests++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL fault_halt_req got %b want 0", req_valid); end
    cyc();
    resp_valid = 0; stall = 0; #1;
    n_tests++; if (req_valid !== 1'b0 || o_pc !== 32'h8000_0008) begin n_fail++; $display("FAIL fault_hold got %b/%h want 0/80000008", req_valid, o_pc); end
    cyc();
    redirect = 1; redirect_pc = 32'h0000_2000; #1;
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL fault_drop got %b want 0", o_valid); end
    cyc();
    redirect = 0; #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h0000_2000) begin n_fail++; $display("FAIL fault_resume got %b/%h want 1/00002000", req_valid, req_pc); end
  endtask

  task automatic test_wrap();
    apply_reset();
    req_ready = 1; redirect = 1; redirect_pc = 32'hFFFF_FFF9;
    cyc();
    redirect = 0; #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_first got %b/%h want 1/fffffff8", req_valid, req_pc); end
    cyc(); #1;
    n_tests++; if (req_valid !== 1'b1 || req_pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_next got %b/%h want 1/00000000", req_valid, req_pc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_low();
    test_credit_stall();
    test_redirect();
    test_redirect_stall();
    test_fault();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
